// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 word generator and self-synchronising checker with HUNT/LOCKED lock tracking.
// Optional `PRBS_ERR_INJECT_EN adds an err_inject port that flips gen_data[0] of the next emitted word.
module prbs_gen_chk #(
  parameter int DATA_W     = 8,
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           poly_sel,
  input  logic                 gen_en,
  input  logic                 chk_valid,
  input  logic [DATA_W-1:0]    chk_data,
  input  logic                 err_clr,
`ifdef PRBS_ERR_INJECT_EN
  input  logic                 err_inject,
`endif
  output logic [DATA_W-1:0]    gen_data,
  output logic                 gen_valid,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sticky
);

  localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int BW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;
  localparam int SW = ((ERR_CNT_W > 6) ? ERR_CNT_W : 6) + 1;
  localparam logic [ERR_CNT_W-1:0] ERR_ALL = '1;

  typedef enum logic {S_HUNT = 1'b0, S_LOCKED = 1'b1} state_t;

  function automatic logic [4:0] poly_len(input logic [1:0] sel);
    case (sel)
      2'd0:    poly_len = 5'd7;
      2'd1:    poly_len = 5'd15;
      2'd2:    poly_len = 5'd23;
      default: poly_len = 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] poly_tap(input logic [1:0] sel);
    case (sel)
      2'd0:    poly_tap = 5'd6;
      2'd1:    poly_tap = 5'd14;
      2'd2:    poly_tap = 5'd18;
      default: poly_tap = 5'd28;
    endcase
  endfunction

  function automatic logic [30+DATA_W:0] gen_step(input logic [30:0] s_in, input logic [4:0] n,
                                                  input logic [4:0] t);
    logic [30:0]       s;
    logic [DATA_W-1:0] w;
    s = s_in;
    w = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w[i] = s[n - 5'd1] ^ s[t - 5'd1];
      s    = {s[29:0], w[i]};
    end
    return {s, w};
  endfunction

  // Received bits, not predictions, feed the register so it re-aligns after N clean bits.
  function automatic logic [30+DATA_W:0] chk_step(input logic [30:0] s_in, input logic [DATA_W-1:0] rx,
                                                  input logic [4:0] n, input logic [4:0] t);
    logic [30:0]       s;
    logic [DATA_W-1:0] mm;
    s  = s_in;
    mm = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      mm[i] = s[n - 5'd1] ^ s[t - 5'd1] ^ rx[i];
      s     = {s[29:0], rx[i]};
    end
    return {s, mm};
  endfunction

  function automatic logic [5:0] popcount(input logic [DATA_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  logic [1:0]           r_poly_q;
  logic [30:0]          r_gen_s;
  logic [30:0]          r_chk_s;
  logic [DATA_W-1:0]    r_gen_data;
  logic                 r_gen_valid;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [GW-1:0]        r_good;
  logic [GW-1:0]        w_good_nxt;
  logic [BW-1:0]        r_bad;
  logic [BW-1:0]        w_bad_nxt;
  logic                 r_locked;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_err_sticky;
  logic                 w_count_en;
  logic                 w_poly_chg;
  logic [4:0]           w_n;
  logic [4:0]           w_t;
  logic [30:0]          w_gen_s;
  logic [DATA_W-1:0]    w_gen_word;
  logic [30:0]          w_chk_s;
  logic [DATA_W-1:0]    w_mm;
  logic                 w_any_mm;
  logic [5:0]           w_pop;
  logic [SW-1:0]        w_sum;
  logic [ERR_CNT_W-1:0] w_err_sat;
  logic                 w_inj;

  assign w_poly_chg = (poly_sel != r_poly_q);
  assign w_n        = poly_len(poly_sel);
  assign w_t        = poly_tap(poly_sel);
  assign {w_gen_s, w_gen_word} = gen_step(r_gen_s, w_n, w_t);
  assign {w_chk_s, w_mm}       = chk_step(r_chk_s, chk_data, w_n, w_t);
  assign w_any_mm  = |w_mm;
  assign w_pop     = popcount(w_mm);
  assign w_sum     = SW'(r_err_count) + SW'(w_pop);
  assign w_err_sat = (w_sum > SW'(ERR_ALL)) ? ERR_ALL : w_sum[ERR_CNT_W-1:0];

`ifdef PRBS_ERR_INJECT_EN
  logic r_inj_arm;
  assign w_inj = r_inj_arm | err_inject;

  // One-shot arm, consumed by the next word actually emitted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_inj_arm <= 1'b0;
    end else if (gen_en && !w_poly_chg) begin
      r_inj_arm <= 1'b0;
    end else if (err_inject) begin
      r_inj_arm <= 1'b1;
    end
  end
`else
  assign w_inj = 1'b0;
`endif

  always_ff @(posedge clk) begin
    r_poly_q <= poly_sel;
  end

  // Generator: a poly change reseeds and swallows any gen_en in that cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_gen_s     <= '1;
      r_gen_data  <= '0;
      r_gen_valid <= 1'b0;
    end else if (w_poly_chg) begin
      r_gen_s     <= '1;
      r_gen_valid <= 1'b0;
    end else if (gen_en) begin
      r_gen_s     <= w_gen_s;
      r_gen_data  <= w_gen_word ^ DATA_W'(w_inj);
      r_gen_valid <= 1'b1;
    end else begin
      r_gen_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_chk_s  <= '0;
      r_state  <= S_HUNT;
      r_good   <= '0;
      r_bad    <= '0;
      r_locked <= 1'b0;
    end else begin
      if (chk_valid) begin
        r_chk_s <= w_chk_s;
      end
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_bad    <= w_bad_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_count_en  = 1'b0;
    if (w_poly_chg) begin
      w_state_nxt = S_HUNT;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
    end else if (chk_valid) begin
      case (r_state)
        S_HUNT: begin
          if (w_any_mm) begin
            w_good_nxt = '0;
          end else if (r_good == GW'(LOCK_CNT - 1)) begin
            w_state_nxt = S_LOCKED;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
          end else begin
            w_good_nxt = r_good + GW'(1);
          end
        end
        S_LOCKED: begin
          w_count_en = 1'b1;
          if (!w_any_mm) begin
            w_bad_nxt = '0;
          end else if (r_bad == BW'(UNLOCK_CNT - 1)) begin
            w_state_nxt = S_HUNT;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
          end else begin
            w_bad_nxt = r_bad + BW'(1);
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
          w_good_nxt  = '0;
          w_bad_nxt   = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Clear beats a same-cycle count.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_err_count  <= '0;
      r_err_sticky <= 1'b0;
    end else if (err_clr) begin
      r_err_count  <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_count_en && w_any_mm) begin
      r_err_count  <= w_err_sat;
      r_err_sticky <= 1'b1;
    end
  end

  assign gen_data   = r_gen_data;
  assign gen_valid  = r_gen_valid;
  assign locked     = r_locked;
  assign err_count  = r_err_count;
  assign err_sticky = r_err_sticky;

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised PRBS generator and checker; the next generation of the team's fixed single-bit PRBS31 source.
- Poly select: PRBS7/15/23/31, chosen at run time.
- Output: DATA_W bits per clock.
- Checker: self-synchronising, with a HUNT/LOCKED state machine and a saturating bit-error counter.
- Sits between on-chip data paths and the pad ring as a BIST source/sink; loopback gen->chk is the standard use.

Parameters:
DATA_W, 8, bits generated/checked per cycle (1..32)
ERR_CNT_W, 16, width of err_count
LOCK_CNT, 16, consecutive error-free valid words to enter LOCKED (>=1)
UNLOCK_CNT, 4, consecutive errored valid words to drop back to HUNT (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous, active-high reset (asserted = 1, despite the name)
poly_sel  input  2  0=PRBS7 x^7+x^6+1, 1=PRBS15 x^15+x^14+1, 2=PRBS23 x^23+x^18+1, 3=PRBS31 x^31+x^28+1
gen_en  input  1  advance generator one word
gen_data  output  DATA_W  generated word
gen_valid  output  1  gen_data valid
chk_valid  input  1  chk_data valid this cycle
chk_data  input  DATA_W  received word
err_clr  input  1  clears err_count and err_sticky
locked  output  1  checker in LOCKED
err_count  output  ERR_CNT_W  saturating mismatched-bit count
err_sticky  output  1  set on any counted mismatch

Behaviour:
- Poly length N and tap T: (7,6), (15,14), (23,18), (31,28). Both LFSRs are 31 bits; only bits [N-1:0] are used.
- Serial step: fb = s[N-1]^s[T-1]; s <= {s[N-2:0], fb}; the emitted bit is fb.
- A word is DATA_W serial steps unrolled combinationally within one cycle. The first step goes to bit DATA_W-1 (MSB first).
- Reset outputs:
  - gen state = all ones in [N-1:0]
  - gen_data = 0, gen_valid = 0
  - chk state = 0, state = HUNT, locked = 0
  - err_count = 0, err_sticky = 0
  - good/bad counters = 0
- Generator:
  - gen_en=1 at edge k gives gen_data/gen_valid registered at edge k (1-cycle latency).
  - gen_en=0 gives gen_valid=0 next cycle; gen_data holds; state holds.
- poly_sel change (registered compare):
  - generator state reseeds to all ones; checker forced to HUNT with counters cleared.
  - err_count is not cleared.
  - A gen_en in the same cycle is ignored (gen_valid=0).
- Checker, per valid word, per bit MSB first:
  - pred = c[N-1]^c[T-1]; mismatch = pred ^ rx_bit.
  - c shifts in rx_bit, not pred, so the checker self-synchronises after N clean bits.
  - One channel bit error produces exactly 3 mismatches (positions 0, T and N after it).
- FSM, updated only when chk_valid=1; chk_valid=0 holds all checker state:
  - HUNT: word with zero mismatches increments good_cnt; any mismatch zeroes it. good_cnt reaching LOCK_CNT -> LOCKED, locked=1 next cycle, bad_cnt=0.
  - LOCKED: err_count += popcount(mismatch), saturating at all ones; err_sticky=1 if any mismatch.
  - LOCKED: an errored word increments bad_cnt; a clean word zeroes it. bad_cnt reaching UNLOCK_CNT -> HUNT, good_cnt=0.
  - Mismatches are never counted in HUNT.
- err_clr: err_count=0 and err_sticky=0 next cycle. If a counted mismatch occurs in the same cycle, clear wins; that word's errors are lost.
- rst_n mid-stream: everything returns to reset values on the next edge, regardless of other inputs.

Optional Feature:
PRBS_ERR_INJECT_EN
- Defined: adds input port err_inject (1 bit). A pulse arms a one-shot that XORs bit 0 of the next generated word (gen_data[0]) before registration. The generator state is not corrupted; the armed flag clears when that word is emitted. Multiple pulses before emission give one injection.
- Undefined: no port and no logic; gen_data is the pure sequence.

Test Plan:
- Reset, poly_sel=0, DATA_W=8, gen_en=1 continuous -> gen_data 8'h02 then 8'h0C on the first two valid cycles; gen_valid rises 1 cycle after gen_en.
- Loopback gen_data->chk_data, chk_valid=gen_valid, for each poly_sel 0..3 -> locked=1 within LOCK_CNT+4 valid words; err_count stays 0 over 10000 words.
- Locked PRBS31 loopback, flip one bit of one chk_data word (or err_inject with the macro) -> err_count=3, err_sticky=1, locked stays 1.
- Locked, then drive chk_data=8'hFF for UNLOCK_CNT valid words -> locked=0 after the UNLOCK_CNT-th word. Restore the stream -> relock after LOCK_CNT+2 clean words.
- Force err_count near saturation (ERR_CNT_W=4, continuous errors while locked) -> holds 4'hF. err_clr together with errors -> err_count=0, err_sticky=0.
- Change poly_sel while locked, and assert rst_n mid-stream -> locked=0 next cycle. gen restarts from the all-ones seed (first PRBS7 word 8'h02). err_count is kept on poly change and zeroed on reset.
